// File: rtl/activation_if.sv
// Channel bundle between an activation stage and its neighbours.
// The argument and propagate channels face the upstream `node`. The result
// and error channels face the next layer.
interface activation_if;
  // Forward input: pre-activation from node's result channel
  logic        argument_valid;
  logic [15:0] argument_data;
  logic        argument_ready;
  // Forward output: 8-bit activation
  logic        result_valid;
  logic [7:0]  result_data;
  logic        result_ready;
  // Backward input: error returned by the next layer
  logic        error_valid;
  logic [15:0] error_data;
  logic        error_ready;
  // Backward output: gated error toward node's error input
  logic        propagate_valid;
  logic [15:0] propagate_data;
  logic        propagate_ready;

  // Activation stage side
  modport slave (
    input  argument_valid, argument_data,
    output argument_ready,
    output result_valid, result_data,
    input  result_ready,
    input  error_valid, error_data,
    output error_ready,
    output propagate_valid, propagate_data,
    input  propagate_ready
  );

  // Environment side (node upstream, next layer downstream)
  modport master (
    output argument_valid, argument_data,
    input  argument_ready,
    input  result_valid, result_data,
    output result_ready,
    output error_valid, error_data,
    input  error_ready,
    input  propagate_valid, propagate_data,
    output propagate_ready
  );
endinterface

// File: rtl/activation.sv
// Hard-saturating ReLU activation stage with a backward error gate.
// Forward pass: the 16-bit signed pre-activation (8 fractional bits) is
// clipped to 0..255 and emitted as an 8-bit activation.
// Backward pass (training only): the returned error passes unchanged where
// the function is linear. Where it is clipped, the error becomes zero, or a
// leaked arithmetic shift when LEAK > 0.
// Only one transaction is in flight. The ready and valid outputs are decoded
// from the state register, so no output depends combinationally on an input
// ready.
module activation #(
  parameter int LEAK = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        train,
  activation_if.slave bus
);

  typedef enum logic [1:0] {
    ARG = 2'd0,  // waiting for a pre-activation
    RES = 2'd1,  // presenting the activation
    ERR = 2'd2,  // waiting for the returned error (training)
    FBK = 2'd3   // presenting the gated error to node
  } state_e;

  state_e             state_q, state_d;
  logic signed [15:0] x_q, x_d;       // stored pre-activation
  logic               d_q, d_d;       // 1 = linear region, derivative is one
  logic        [15:0] prop_q, prop_d; // registered gated error

  logic               arg_hs, res_hs, err_hs, prop_hs;
  logic signed [15:0] arg_x;
  logic               arg_linear;
  logic        [7:0]  y;
  logic signed [15:0] err_e;
  logic signed [15:0] err_leaked;
  logic        [15:0] err_gated;

  // Handshake decode. Ready is a function of the state alone.
  always_comb begin
    bus.argument_ready  = (state_q == ARG);
    bus.error_ready     = (state_q == ERR);
    bus.result_valid    = (state_q == RES);
    bus.propagate_valid = (state_q == FBK);
    arg_hs  = bus.argument_valid  & bus.argument_ready;
    res_hs  = bus.result_valid    & bus.result_ready;
    err_hs  = bus.error_valid     & bus.error_ready;
    prop_hs = bus.propagate_valid & bus.propagate_ready;
  end

  // Derivative of the incoming argument. Both clip edges (0 and 255) count
  // as clipped, so the linear region is the open interval.
  always_comb begin
    arg_x      = $signed(bus.argument_data);
    arg_linear = (arg_x > 16'sd0) && (arg_x < 16'sd255);
  end

  // Forward function on the stored x. Because x_q holds after the result
  // handshake, result_data keeps its last value without a separate register.
  always_comb begin
    if (x_q <= 16'sd0)
      y = 8'd0;
    else if (x_q >= 16'sd255)
      y = 8'd255;
    else
      y = x_q[7:0];
    bus.result_data = y;
  end

  // Backward gate. The shift is arithmetic and does not saturate, so a
  // negative error stays negative.
  always_comb begin
    err_e      = $signed(bus.error_data);
    err_leaked = err_e >>> LEAK;
    if (d_q)
      err_gated = err_e;
    else if (LEAK == 0)
      err_gated = 16'd0;
    else
      err_gated = err_leaked;
  end

  assign bus.propagate_data = prop_q;

  // Next-state and datapath updates. Every register holds by default and
  // changes only on its own channel's handshake.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    d_d     = d_q;
    prop_d  = prop_q;
    unique case (state_q)
      ARG: begin
        if (arg_hs) begin
          x_d     = arg_x;
          d_d     = arg_linear;
          state_d = RES;
        end
      end
      RES: begin
        // train is sampled only here; changes at other times have no effect
        if (res_hs)
          state_d = train ? ERR : ARG;
      end
      ERR: begin
        if (err_hs) begin
          prop_d  = err_gated;
          state_d = FBK;
        end
      end
      FBK: begin
        if (prop_hs)
          state_d = ARG;
      end
      default: state_d = ARG;
    endcase
  end

  // State and data registers. Reset abandons any transaction in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ARG;
      x_q     <= '0;
      d_q     <= 1'b0;
      prop_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      d_q     <= d_d;
      prop_q  <= prop_d;
    end
  end

  // A state register holding an unknown value is a fatal error.
  state_known_a: assert property (@(posedge clock) disable iff (reset)
                                  !$isunknown(state_q))
    else $fatal(1, "activation: illegal state encoding");

endmodule
